// File: rtl/score_disp_pkg.sv
// Shared constants, segment table and conversion FSM states
// for the multiplexed score display.
package score_disp_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t SHIFT  = 2'd1;
    localparam state_t COMMIT = 2'd2;

    // Active-low segments, bit7 = dp (unlit), bits6..0 = g..a.
    function automatic logic [7:0] seg_of(input logic [3:0] d);
        logic [7:0] s;
        unique case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic int unsigned pow10(input int n);
        int unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter with saturation and a
// single-entry pending slot for loads that arrive while busy.
module bin2bcd_seq
    import score_disp_pkg::*;
#(
    parameter int VALUE_W    = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [VALUE_W-1:0]      value,
    output logic                    busy,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    valid,
    output logic                    overflow
);

    localparam int BW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(VALUE_W + 1);
    localparam logic [VALUE_W-1:0] MAXV =
        VALUE_W'(pow10(NUM_DIGITS) - 1);

    state_t             state;
    logic [VALUE_W-1:0] bin;
    logic [VALUE_W-1:0] pend_val;
    logic               pend;
    logic [BW-1:0]      acc;
    logic [BW-1:0]      adj;
    logic [CW-1:0]      cnt;
    logic               start;
    logic [VALUE_W-1:0] src;

    // A load during COMMIT wins over an older pending value.
    always_comb begin
        start = ((state == IDLE) && load) ||
                ((state == COMMIT) && (load || pend));
        src   = ((state == COMMIT) && !load) ? pend_val : value;
    end

    always_comb begin
        adj = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            adj[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ?
                            acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bin      <= '0;
            pend_val <= '0;
            pend     <= 1'b0;
            acc      <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else if (start) begin
            bin      <= (src > MAXV) ? MAXV : src;
            overflow <= (src > MAXV);
            acc      <= '0;
            cnt      <= '0;
            pend     <= 1'b0;
            state    <= SHIFT;
        end else begin
            if (load && (state != IDLE)) begin
                pend     <= 1'b1;
                pend_val <= value;
            end
            unique case (state)
                SHIFT: begin
                    acc <= {adj[BW-2:0], bin[VALUE_W-1]};
                    bin <= {bin[VALUE_W-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(VALUE_W - 1)) state <= COMMIT;
                end
                COMMIT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state == SHIFT);
    assign valid = (state == COMMIT);
    assign bcd   = acc;

endmodule

// File: rtl/score_display_scan.sv
// Multiplexed seven-segment score driver: refresh scan, leading-zero
// blanking, decimal points and game-over blink.
module score_display_scan
    import score_disp_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int VALUE_W       = 14,
    parameter int REFRESH_DIV   = 100000,
    parameter int BLINK_DIV     = 25000000,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [VALUE_W-1:0]    value,
    input  logic                  load,
    input  logic                  blink_en,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  busy,
    output logic                  overflow
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BLW = $clog2(BLINK_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] bcd;
    logic [4*NUM_DIGITS-1:0] disp;
    logic                    valid;
    logic [RW-1:0]           rcnt;
    logic [BLW-1:0]          bcnt;
    logic                    rtick;
    logic                    btick;
    logic                    phase_on;
    logic [IW-1:0]           idx;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    zero_above;
    logic [7:0]              base;
    logic [7:0]              seg_next;
    logic [7:0]              seg_scan;
    logic [NUM_DIGITS-1:0]   an_scan;

    bin2bcd_seq #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .value    (value),
        .busy     (busy),
        .bcd      (bcd),
        .valid    (valid),
        .overflow (overflow)
    );

    assign rtick = (rcnt == RW'(REFRESH_DIV - 1));
    assign btick = (bcnt == BLW'(BLINK_DIV - 1));

    // Digit i blanks when it and every digit above it are zero.
    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (disp[4*i +: 4] == 4'd0);
            blank[i]   = (BLANK_LEADING != 0) && (i > 0) && zero_above;
        end
        base     = blank[idx] ? SEG_BLANK : seg_of(disp[4*idx +: 4]);
        seg_next = {base[7] & ~dp_mask[idx], base[6:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp     <= '0;
            rcnt     <= '0;
            bcnt     <= '0;
            phase_on <= 1'b1;
            idx      <= '0;
            seg_scan <= SEG_BLANK;
            an_scan  <= '1;
            seg      <= SEG_BLANK;
            an       <= '1;
        end else begin
            if (valid) disp <= bcd;
            rcnt <= rtick ? '0 : rcnt + 1'b1;
            bcnt <= btick ? '0 : bcnt + 1'b1;
            if (btick) phase_on <= ~phase_on;
            if (rtick) begin
                seg_scan <= seg_next;
                an_scan  <= ~(NUM_DIGITS'(1) << idx);
                idx      <= (idx == IW'(NUM_DIGITS - 1)) ?
                            '0 : idx + 1'b1;
            end
            seg <= seg_scan;
            an  <= (blink_en && !phase_on) ? '1 : an_scan;
        end
    end

endmodule

// File: doc/score_display_scan.md
Name: score_display_scan

Overview:
- Parametrised multiplexed seven-segment score display driver for the Tetris top level.
- Converts a binary score to BCD with a sequential double-dabble engine, then time-multiplexes NUM_DIGITS active-low anodes.
- Adds features the current score display lacks:
  - leading-zero blanking
  - per-digit decimal points
  - saturation with an overflow flag
  - game-over blink mode
- Runs from the single system clock, with internal refresh and blink dividers.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..8).
- VALUE_W, 14, binary input width; must satisfy 2^VALUE_W > 10^NUM_DIGITS - 1.
- REFRESH_DIV, 100000, clk cycles per digit slot (>=2).
- BLINK_DIV, 25000000, clk cycles per blink half-period (>=2).
- BLANK_LEADING, 1, 1 = blank leading zeros; 0 = show all digits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- value  in  VALUE_W  binary score to display.
- load  in  1  single-cycle pulse; capture value and start conversion.
- blink_en  in  1  1 = blink whole display (game over).
- dp_mask  in  NUM_DIGITS  1 = light decimal point of that digit (bit 0 = rightmost).
- seg  out  8  active-low segments; bit7 = dp, bits6..0 = g..a.
- an  out  NUM_DIGITS  active-low one-hot anode select.
- busy  out  1  conversion in progress.
- overflow  out  1  last loaded value exceeded 10^NUM_DIGITS - 1.

Behaviour:
- Reset (async, rst_n low):
  - Outputs: seg=8'hFF, an=all 1s, busy=0, overflow=0.
  - Internal state: BCD display register=0, digit index=0, refresh/blink counters=0, blink phase=on, pending=0.
- Conversion FSM states: IDLE, SHIFT, COMMIT.
  - IDLE + load: latch value. If value > 10^NUM_DIGITS-1, substitute 10^NUM_DIGITS-1 and set overflow=1; else overflow=0. Go to SHIFT; busy=1 the next cycle.
  - SHIFT: one double-dabble step per cycle (add 3 to any nibble >=5, then shift left by 1) for exactly VALUE_W cycles, then go to COMMIT.
  - COMMIT: copy the BCD result to the display register atomically in one cycle; busy=0. Go to IDLE, or back to SHIFT if pending is set.
- Latency: load to display-register update = VALUE_W+2 cycles. The new value appears on seg at the next digit slot.
- load while busy: value latched into the pending register (last one wins). It is converted immediately after COMMIT. The current conversion is never aborted.
- load in the same cycle as COMMIT: treated as pending.
- Display register is never partially updated: no torn digits.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the digit index advances.
  - Index wraps NUM_DIGITS-1 -> 0.
  - an and seg are registered and change together on the tick cycle.
- Digit encoding, active-low, dp bit set (1) when unlit: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Any nibble >9 displays blank (FF).
- dp_mask[i]=1 clears seg[7] while digit i is selected.
- Leading-zero blanking (BLANK_LEADING=1):
  - Digit i is blanked (seg=FF, dp still honoured) when it and all higher digits are 0, for i>0.
  - Digit 0 is always shown, so value 0 displays "0".
- Blink:
  - Blink counter runs continuously. At terminal count the phase toggles.
  - When blink_en=1 and phase=off, an=all 1s; scanning continues underneath.
  - When blink_en=0, an is never forced off.
  - Deassertion takes effect on the next cycle.
- Reset mid-conversion aborts everything and returns to reset values. The old display content is not retained.

Decomposition:
- Shared package score_disp_pkg holds:
  - SEG_BLANK=8'hFF
  - the digit-to-segment constant table/function
  - FSM state typedef (IDLE/SHIFT/COMMIT)
- Sub-module bin2bcd_seq (params VALUE_W, NUM_DIGITS) holds the conversion FSM, pending register and saturation; its ports are load/value in, busy/bcd/valid out.
- score_display_scan holds the dividers, scan mux, blanking and blink.

Test Plan (sim with REFRESH_DIV=4, BLINK_DIV=16, NUM_DIGITS=4, VALUE_W=14):
- Reset, then load 1234 -> busy high for 14 cycles; after the next 4 slots, seg sequence 99,B0,A4,F9 with an 1110,1101,1011,0111.
- load 7 with BLANK_LEADING=1 -> digit0 seg=F8; digits 1-3 seg=FF. load 0 -> digit0 C0, others FF.
- load 12000 -> overflow=1, all digits display 9 (seg=90). Then load 5 -> overflow=0.
- load 1111, then load 2222 at busy cycle 3 -> display reaches 1111, then 2222 within VALUE_W+2 cycles of first COMMIT; never a mixed digit.
- blink_en=1 -> an all 1s for 16 cycles, scanning for 16, repeating. dp_mask=0010 -> seg[7]=0 only in the digit-1 slot.
- Assert rst_n low during SHIFT -> seg=FF, an=1111, busy=0 immediately (async); after release, load 42 displays 42 normally.
